// File: rtl/trivium_stream_ctrl.sv
// Session sequencer for a single Trivium keystream core: load, warm-up wait,
// serial-to-parallel packing of keystream bits and valid/ready word delivery.
module trivium_stream_ctrl #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [79:0]           key,
  input  logic [79:0]           iv,
  input  logic [15:0]           num_words,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] ks_word,
  output logic                  ks_valid,
  input  logic                  ks_ready,
  output logic                  core_rst,
  output logic                  core_en,
  output logic [79:0]           core_key,
  output logic [79:0]           core_iv,
  input  logic                  core_warm_up_complete,
  input  logic                  core_key_stream
);

  localparam int BCW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WARM,
    S_GEN,
    S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic                  done_q, done_d;
  logic [79:0]           key_q, key_d;
  logic [79:0]           iv_q, iv_d;
  logic [15:0]           words_left_q, words_left_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] ks_word_q, ks_word_d;

  // Handshake: a word transfers on a rising edge where ks_valid and ks_ready
  // are both high; once raised, ks_valid holds (with ks_word stable) until
  // that transfer or an abort.
  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    key_d        = key_q;
    iv_d         = iv_q;
    words_left_d = words_left_q;
    bit_cnt_d    = bit_cnt_q;
    ks_word_d    = ks_word_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d        = key;
          iv_d         = iv;
          words_left_d = num_words;
          bit_cnt_d    = '0;
          if (num_words == 16'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        state_d = S_WARM;
      end
      S_WARM: begin
        // LOAD cleared the core's warm-up counter, so this flag is fresh.
        if (core_warm_up_complete) begin
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        ks_word_d[bit_cnt_q] = core_key_stream;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = S_OUT;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (ks_ready) begin
          words_left_d = words_left_q - 16'd1;
          if (words_left_q == 16'd1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GEN;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      done_d       = 1'b0;
      bit_cnt_d    = '0;
      words_left_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      done_q       <= 1'b0;
      key_q        <= '0;
      iv_q         <= '0;
      words_left_q <= '0;
      bit_cnt_q    <= '0;
      ks_word_q    <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      key_q        <= key_d;
      iv_q         <= iv_d;
      words_left_q <= words_left_d;
      bit_cnt_q    <= bit_cnt_d;
      ks_word_q    <= ks_word_d;
    end
  end

  // Core controls decode straight from the state register so an async reset
  // drops them without waiting for a clock.
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign ks_valid = (state_q == S_OUT);
  assign ks_word  = ks_word_q;
  assign core_rst = (state_q == S_LOAD);
  assign core_en  = (state_q == S_GEN);
  assign core_key = key_q;
  assign core_iv  = iv_q;

endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// Directed bench for trivium_stream_ctrl with a behavioural Trivium core and
// an independent reference keystream feeding an expected-word queue.
module tb_trivium_stream_ctrl;

  localparam int W = 32;
  localparam int WARM_STEPS = 1152;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [79:0]  key = '0;
  logic [79:0]  iv = '0;
  logic [15:0]  num_words = '0;
  logic         busy, done, ks_valid, ks_ready;
  logic [W-1:0] ks_word;
  logic         core_rst, core_en, core_warm_up_complete, core_key_stream;
  logic [79:0]  core_key, core_iv;

  int total = 0;
  int bad = 0;
  int cur = 0;
  logic [W-1:0] exp_q[$];

  trivium_stream_ctrl #(.WORD_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .key(key), .iv(iv), .num_words(num_words),
    .busy(busy), .done(done), .ks_word(ks_word), .ks_valid(ks_valid),
    .ks_ready(ks_ready), .core_rst(core_rst), .core_en(core_en),
    .core_key(core_key), .core_iv(core_iv),
    .core_warm_up_complete(core_warm_up_complete),
    .core_key_stream(core_key_stream)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- Trivium arithmetic ----------------
  function automatic logic [288:1] tv_load(input logic [79:0] k, input logic [79:0] v);
    logic [288:1] s;
    s = '0;
    for (int i = 0; i < 80; i++) begin
      s[i + 1]  = k[i];
      s[i + 94] = v[i];
    end
    s[286] = 1'b1;
    s[287] = 1'b1;
    s[288] = 1'b1;
    return s;
  endfunction

  function automatic logic tv_z(input logic [288:1] s);
    return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
  endfunction

  function automatic logic [288:1] tv_step(input logic [288:1] s);
    logic t1, t2, t3;
    logic [288:1] n;
    t1 = s[66] ^ s[93] ^ (s[91] & s[92]) ^ s[171];
    t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
    t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
    n = s;
    n[93:1]    = {s[92:1], t3};
    n[177:94]  = {s[176:94], t1};
    n[288:178] = {s[287:178], t2};
    return n;
  endfunction

  // Reference: word idx of the stream for (k, v), bit i of the word = i-th bit.
  function automatic logic [W-1:0] ref_word(input logic [79:0] k, input logic [79:0] v, input int idx);
    logic [288:1] s;
    logic [W-1:0] w;
    s = tv_load(k, v);
    for (int i = 0; i < WARM_STEPS + W * idx; i++) s = tv_step(s);
    w = '0;
    for (int i = 0; i < W; i++) begin
      w[i] = tv_z(s);
      s = tv_step(s);
    end
    return w;
  endfunction

  // ---------------- behavioural core ----------------
  logic [288:1] cs = '0;
  int ccnt = 0;
  always @(posedge clk) begin
    if (core_rst) begin
      cs   <= tv_load(core_key, core_iv);
      ccnt <= 0;
    end else if (ccnt < WARM_STEPS) begin
      cs   <= tv_step(cs);
      ccnt <= ccnt + 1;
    end else if (core_en) begin
      cs <= tv_step(cs);
    end
  end
  assign core_warm_up_complete = (ccnt == WARM_STEPS);
  assign core_key_stream = tv_z(cs);

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cur++;
  endtask

  task automatic do_start(input logic [79:0] k, input logic [79:0] v, input logic [15:0] n);
    key = k;
    iv = v;
    num_words = n;
    start = 1'b1;
    cur = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic push_words(input logic [79:0] k, input logic [79:0] v, input int first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ref_word(k, v, first + i));
  endtask

  task automatic wait_valid(input int limit, output int at);
    while (!ks_valid && cur < limit) tick();
    check("valid_timeout", ks_valid, 1'b1);
    at = cur;
  endtask

  task automatic take_word(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      check(tag, ks_word, e);
    end
  endtask

  function automatic logic [79:0] rand_key();
    logic [79:0] r;
    for (int i = 0; i < 10; i++) r[i*8 +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [79:0] key_a, iv_a, key_b, key_r, iv_r;
    int at;
    key_a = 80'h0123456789abcdef0123;
    iv_a  = 80'hfedcba98765432100f0f;
    key_b = rand_key();
    key_r = rand_key();
    iv_r  = rand_key();
    ks_ready = 1'b1;

    // reset
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", ks_valid, 1'b0);
    check("rst_core_rst", core_rst, 1'b0);
    check("rst_core_en", core_en, 1'b0);
    check("rst_ks_word", ks_word, '0);
    check("rst_core_key", core_key, '0);
    check("rst_core_iv", core_iv, '0);
    rst = 1'b0;
    tick();

    // nominal, 2 words, key=iv=0
    push_words('0, '0, 0, 2);
    do_start('0, '0, 16'd2);
    check("nom_load_core_rst", core_rst, 1'b1);
    check("nom_load_busy", busy, 1'b1);
    tick();
    check("nom_warm_core_rst", core_rst, 1'b0);
    check("nom_warm_core_en", core_en, 1'b0);
    wait_valid(3000, at);
    check("nom_valid0_cycle", at, 1187);
    take_word("nom_word0");
    tick();
    wait_valid(3000, at);
    check("nom_valid1_cycle", at, 1220);
    take_word("nom_word1");
    tick();
    check("nom_done", done, 1'b1);
    check("nom_done_busy", busy, 1'b0);
    tick();
    check("nom_done_pulse", done, 1'b0);

    // backpressure, 3 words, 10-cycle stall on word 0
    ks_ready = 1'b0;
    push_words(key_a, iv_a, 0, 3);
    do_start(key_a, iv_a, 16'd3);
    wait_valid(3000, at);
    for (int i = 0; i < 10; i++) begin
      check("bp_word_stable", ks_word, exp_q[0]);
      check("bp_core_en", core_en, 1'b0);
      check("bp_valid_held", ks_valid, 1'b1);
      tick();
    end
    ks_ready = 1'b1;
    take_word("bp_word0");
    tick();
    wait_valid(cur + 100, at);
    take_word("bp_word1");
    tick();
    wait_valid(cur + 100, at);
    take_word("bp_word2");
    tick();
    check("bp_done", done, 1'b1);
    tick();

    // abort during GEN, then same key/IV again
    do_start('0, '0, 16'd2);
    while (cur < 1160) tick();
    check("ab_in_gen", core_en, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", busy, 1'b0);
    check("ab_core_en", core_en, 1'b0);
    check("ab_valid", ks_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("ab_no_done", done, 1'b0);
      tick();
    end
    push_words('0, '0, 0, 1);
    do_start('0, '0, 16'd1);
    wait_valid(3000, at);
    check("ab_restart_cycle", at, 1187);
    take_word("ab_restart_word");
    tick();
    check("ab_restart_done", done, 1'b1);
    tick();

    // zero words
    do_start(key_a, iv_a, 16'd0);
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_core_rst", core_rst, 1'b0);
    tick();
    check("zero_done_pulse", done, 1'b0);
    check("zero_busy2", busy, 1'b0);
    check("zero_core_rst2", core_rst, 1'b0);

    // start while busy is ignored
    push_words(key_a, iv_a, 0, 1);
    do_start(key_a, iv_a, 16'd1);
    while (cur < 100) tick();
    key = key_b;
    iv = key_b;
    num_words = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sb_core_key", core_key, key_a);
    check("sb_core_iv", core_iv, iv_a);
    wait_valid(3000, at);
    check("sb_valid_cycle", at, 1187);
    take_word("sb_word");
    tick();
    check("sb_done", done, 1'b1);
    tick();
    check("sb_idle", busy, 1'b0);

    // async reset while in OUT
    ks_ready = 1'b0;
    push_words(key_a, iv_a, 0, 1);
    do_start(key_a, iv_a, 16'd2);
    wait_valid(3000, at);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", ks_valid, 1'b0);
    check("ar_busy", busy, 1'b0);
    check("ar_core_en", core_en, 1'b0);
    check("ar_core_key", core_key, '0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    check("ar_idle", busy, 1'b0);
    ks_ready = 1'b1;
    push_words(key_r, iv_r, 0, 2);
    do_start(key_r, iv_r, 16'd2);
    wait_valid(3000, at);
    check("ar_valid_cycle", at, 1187);
    take_word("ar_word0");
    tick();
    wait_valid(cur + 100, at);
    take_word("ar_word1");
    tick();
    check("ar_done", done, 1'b1);
    check("ar_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trivium_stream_ctrl.md
# trivium_stream_ctrl

Sequencing controller for the `trivium` keystream core. It latches a key/IV pair and a requested word count, and loads the core. It waits out the 1152-cycle warm-up, then gates the core's `en` to pack serial keystream bits into `WORD_WIDTH`-bit words. Words are delivered over a valid/ready handshake. It sits between a bus-side requester (cipher/XOR datapath) and a single `trivium` instance, and is the only driver of that core's `rst`/`en`/`key`/`iv`.

## Interface
- `WORD_WIDTH`, 32, keystream word width in bits (legal range 1..64).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  session request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; valid in any non-IDLE state.
- `key`  in  80  session key; latched on accepted `start`.
- `iv`  in  80  session IV; latched on accepted `start`.
- `num_words`  in  16  words to produce; latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last word has been handed over.
- `ks_word`  out  WORD_WIDTH  keystream word; bit i is the i-th keystream bit of that word, LSB first.
- `ks_valid`  out  1  `ks_word` is valid.
- `ks_ready`  in  1  consumer accepts `ks_word` when high together with `ks_valid`.
- `core_rst`  out  1  to core `rst` (synchronous load of key/IV, clears core warm-up counter).
- `core_en`  out  1  to core `en`.
- `core_key`, `core_iv`  out  80 each  latched key/IV, held stable for the whole session.
- `core_warm_up_complete`  in  1  from core.
- `core_key_stream`  in  1  from core.

## Operation
- **Reset:** state IDLE. `busy`, `done`, `ks_valid`, `core_rst` and `core_en` are 0. `ks_word`, `core_key` and `core_iv` are all-zero. The words-left counter and bit counter are 0.
- **IDLE:** `start`=1 latches key/IV/`num_words`.
  - `num_words`=0: go to IDLE and pulse `done` in the next cycle; `core_rst` is never asserted.
  - Otherwise go to LOAD. `start` outside IDLE is ignored.
- **LOAD** (exactly 1 cycle): `core_rst`=1, `core_en`=0 → WARM.
- **WARM:** `core_en`=0, waiting for `core_warm_up_complete`. When it is 1, go to GEN in the next cycle. The core's stale `warm_up_complete` cannot be seen here because LOAD has already cleared its counter.
- **GEN:** `core_en`=1.
  - Each cycle, `core_key_stream` is written into `ks_word[bit_cnt]` and `bit_cnt` increments.
  - After the bit with `bit_cnt`=WORD_WIDTH-1, clear `bit_cnt` and go to OUT.
- **OUT:** `ks_valid`=1, `core_en`=0, `ks_word` held stable. On `ks_valid & ks_ready`, decrement words_left:
  - If the word just sent was the last, go to IDLE and pulse `done` in the next cycle.
  - Otherwise go to GEN.
- **abort:** from any non-IDLE state, go to IDLE next edge. `ks_valid`, `core_en` and `core_rst` drop, no `done` pulse, `ks_word` contents undefined until the next word.
- **Keystream continuity:** a bit is consumed only in a cycle where `core_en`=1, so stalls never drop or duplicate bits.
- **Width rule:** words_left is 16 bits; `bit_cnt` is $clog2(WORD_WIDTH) bits, minimum 1.

## Timing
- Let `start` be sampled in cycle 0. Then:
  - LOAD in cycle 1.
  - WARM from cycle 2; core counter reaches 1152 in cycle 1154.
  - GEN occupies cycles 1155..1154+WORD_WIDTH.
  - First `ks_valid` in cycle 1155+WORD_WIDTH.
- With `ks_ready` tied high, one word every WORD_WIDTH+1 cycles.
- `done` is asserted in the cycle after the final handshake, for exactly 1 cycle; `busy` is 0 in that same cycle.
- Once `ks_valid` rises, it stays high until the handshake or an abort.
- Async `rst` mid-operation: all outputs go to their reset values immediately, independent of `clk`.

## Test plan
- **Nominal, 2 words:** WORD_WIDTH=32, key=0, iv=0, `num_words`=2, `ks_ready`=1.
  - Required: `ks_valid` in cycles 1187 and 1220, `done` in cycle 1221.
  - Both words match a bit-accurate Trivium model bit-for-bit, LSB first.
- **Backpressure:** hold `ks_ready`=0 for 10 cycles on word 0 of a 3-word request.
  - Required: `ks_word` stable, `core_en`=0 throughout the stall.
  - Words 1 and 2 are identical to the no-stall run.
- **Abort:** `abort`=1 in GEN cycle 1160.
  - Required: IDLE, `busy`=0 and `core_en`=0 next cycle, no `done`.
  - A following `start` with the same key/IV reproduces the nominal first word.
- **Zero words:** `start` with `num_words`=0.
  - Required: `done`=1 in cycle 1, `busy` never high, `core_rst` never asserted.
- **Start while busy:** pulse `start` with a different key during WARM.
  - Required: ignored; `core_key` unchanged, output matches the original key's stream.
- **Async reset:** assert `rst` between clock edges while in OUT.
  - Required: `ks_valid`, `busy` and `core_en` go to 0 immediately; IDLE after release; the next session is correct.
